// File: rtl/cpu_pkg.sv
// Shared CPU types and constants: word type, reset PC, NOP encoding,
// and the instruction-fetch FSM state enum.
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t RESET_PC = 32'h0000_3000;
    localparam word_t NOP      = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    // Fetch addresses are always word aligned; low bits are dropped.
    function automatic word_t word_align(input word_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry IF/ID output buffer holding {pc_plus_4, instruction, valid}.
// Ports: clk, rst (async high); flush_i > load_i > consume_i priority;
//   pc_plus_4_i/instr_i load data; pc_plus_4_o/instr_o/valid_o registered.
module fetch_out_buf import cpu_pkg::*; #(
    parameter word_t RESET_PC = cpu_pkg::RESET_PC,
    parameter word_t NOP      = cpu_pkg::NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic        consume_i,
    input  logic [31:0] pc_plus_4_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_plus_4_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] pc_plus_4_q;
    logic [31:0] instr_q;
    logic        valid_q;

    // pc_plus_4 is left untouched by flush/consume; only valid and
    // the instruction word fall back to a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_plus_4_q <= RESET_PC;
            instr_q     <= NOP;
            valid_q     <= 1'b0;
        end else if (flush_i) begin
            instr_q     <= NOP;
            valid_q     <= 1'b0;
        end else if (load_i) begin
            pc_plus_4_q <= pc_plus_4_i;
            instr_q     <= instr_i;
            valid_q     <= 1'b1;
        end else if (consume_i) begin
            instr_q     <= NOP;
            valid_q     <= 1'b0;
        end
    end

    assign pc_plus_4_o = pc_plus_4_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem
// requests and presents {pc_plus_4, instruction, valid} to IF/ID.
// Ports: clk, rst (async high); stall, redirect_valid/redirect_pc from
//   hazard/branch logic; imem_req/imem_addr/imem_gnt/imem_rvalid/
//   imem_rdata to instruction memory; o_pc_plus_4/o_instruction/o_valid.
module if_fetch_unit import cpu_pkg::*; #(
    parameter word_t RESET_PC = cpu_pkg::RESET_PC,
    parameter word_t NOP      = cpu_pkg::NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] o_pc_plus_4,
    output logic [31:0] o_instruction,
    output logic        o_valid
);

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        req_pc_q, req_pc_d;
    logic         buf_load;
    logic         buf_consume;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        imem_req = 1'b0;
        buf_load = 1'b0;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                // Never request while a stalled instruction is parked.
                imem_req = !(o_valid && stall);
                if (imem_req && imem_gnt) begin
                    if (redirect_valid) begin
                        // Grant is stale; wait out its response.
                        state_d = DROP;
                    end else begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    state_d  = REQ;
                    buf_load = !redirect_valid;
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_rvalid) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) pc_d = word_align(redirect_pc);
    end

    assign imem_addr   = pc_q;
    assign buf_consume = o_valid && !stall;

    fetch_out_buf #(
        .RESET_PC (RESET_PC),
        .NOP      (NOP)
    ) u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .load_i      (buf_load),
        .consume_i   (buf_consume),
        .pc_plus_4_i (req_pc_q + 32'd4),
        .instr_i     (imem_rdata),
        .pc_plus_4_o (o_pc_plus_4),
        .instr_o     (o_instruction),
        .valid_o     (o_valid)
    );

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the pipelined CPU: owns the PC, issues single-outstanding requests to instruction memory, and presents `{pc_plus_4, instruction}` with a valid flag to the IF/ID pipeline register. It honours the load-use stall from the hazard unit and the branch/jump redirect from decode/execute. In-flight fetches made stale by a redirect are discarded.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC after reset.
- `NOP`, default 32'h0000_0000: instruction value driven when no fetch is valid.
- `clk  in  1`: clock; all state changes on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `stall  in  1`: load-use stall; the presented instruction is not consumed.
- `redirect_valid  in  1`: taken branch, jump or jr; flushes fetch.
- `redirect_pc  in  32`: new fetch address; word aligned.
- `imem_req  out  1`: fetch request.
- `imem_addr  out  32`: fetch address.
- `imem_gnt  in  1`: request accepted this cycle.
- `imem_rvalid  in  1`: read data valid; exactly one per granted request.
- `imem_rdata  in  32`: instruction word.
- `o_pc_plus_4  out  32`: address of the presented instruction plus 4.
- `o_instruction  out  32`: presented instruction.
- `o_valid  out  1`: presented instruction is real (0 means bubble).

## Operation
- **Registers:**
  - `pc`: next address to request.
  - `req_pc`: address of the in-flight request.
  - Single-entry output buffer: `o_pc_plus_4`, `o_instruction`, `o_valid`.
  - FSM state.
- **Consumption:** the buffer is consumed at a rising edge where `o_valid && !stall`.
- **FSM states:**
  - IDLE: exits to REQ on the first edge after reset.
  - REQ:
    - `imem_req = !(o_valid && stall)`; `imem_addr = pc`.
    - On `imem_req && imem_gnt`: `req_pc <= pc`, `pc <= pc + 4`, go to WAIT.
  - WAIT: on `imem_rvalid`:
    - Buffer loads `{req_pc + 4, imem_rdata}` and `o_valid <= 1`.
    - Go to REQ.
    - The buffer is guaranteed free or consumed this edge, because requests are issued only when the buffer is not stalled-full.
  - DROP: on `imem_rvalid`, discard the data and go to REQ.
- **Buffer without a new load:** on consumption, `o_valid <= 0` and `o_instruction <= NOP`.
- **Redirect (highest priority; overrides stall):**
  - Every state: `pc <= redirect_pc`, `o_valid <= 0`, `o_instruction <= NOP`.
  - REQ without gnt: stay in REQ.
  - REQ with gnt the same cycle: go to DROP; the grant is discarded and `pc` is *not* incremented.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid the same cycle: discard the data, go to REQ.
  - DROP: `pc` is updated, stay in DROP (or go to REQ if rvalid the same cycle).
  - IDLE: `pc` is updated, go to REQ.
- **Stall with a full buffer:** all outputs hold; no new request is issued. WAIT may still complete only if the buffer is being consumed, which the request rule guarantees.
- **Arithmetic:** `pc + 4` is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. `redirect_pc[1:0]` is ignored and forced to 0.

## Timing
- **Reset values:**
  - `pc = RESET_PC`, state IDLE.
  - `imem_req = 0`, `imem_addr = RESET_PC`.
  - `o_valid = 0`, `o_instruction = NOP`, `o_pc_plus_4 = RESET_PC`.
- **Latency:** with gnt in the REQ cycle *n* and rvalid in cycle *n+1*, `o_valid` rises at *n+2*.
- **Throughput:** 1 instruction per 2 cycles at zero memory wait.
- **Outputs:** `imem_req` and `imem_addr` are combinational from state, `pc`, `o_valid` and `stall`. All IF/ID-facing outputs are registered.
- **Reset mid-operation:** returns to reset values immediately. Any later rvalid belonging to a pre-reset request is the memory's responsibility; the memory is reset by the same `rst`.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC` and `NOP` constants.
  - `fetch_state_t` enum {IDLE, REQ, WAIT, DROP}.
  - 32-bit word typedef.
- One natural sub-module: `fetch_out_buf`, the single-entry buffer with load, consume and flush controls. The FSM and PC logic stay in `if_fetch_unit`.

## Test plan
- **Reset then free-run:** memory with gnt=1 and rvalid one cycle later returns 32'h2001_0005 at 32'h3000.
  - `o_valid` is 1 at cycle 3 with `o_pc_plus_4` = 32'h3004.
  - The next request address is 32'h3004.
- **Stall:** hold `stall=1` for 3 cycles while `o_valid=1`.
  - Outputs are unchanged.
  - `imem_req` stays 0.
  - After release, the next request is issued.
- **Redirect in WAIT:** `redirect_pc` = 32'h3100 with no rvalid yet.
  - The late rvalid data is dropped.
  - `o_valid` stays 0.
  - The next `imem_addr` is 32'h3100.
- **Redirect and gnt in the same REQ cycle:** the response is discarded (DROP), then 32'h3100 is requested. `pc` never becomes `old_pc + 4`.
- **Redirect with stall:** the flush wins; `o_valid` is 0 on the next cycle.
- **Wrap:** a redirect to 32'hFFFF_FFFC gives `o_pc_plus_4` = 0, and the next fetch address is 0.
